ps2_frame_rx: RTL

Assembles 11-bit PS/2 device-to-host frames (start, 8 data LSB-first, odd parity, stop) into bytes. Sits directly downstream of the PS/2 clock debounce stage: it consumes that stage's one-cycle edge strobe as the bit-sampling instant and samples the synchronized PS/2 data line on each strobe. It emits each received byte with a one-cycle valid pulse, or an error pulse, to the scan-code decoder.

---
 rtl/ps2_pkg.sv | 19 +
 rtl/sync2.sv | 27 ++
 rtl/ps2_frame_rx.sv | 109 ++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: frame geometry and the receive/transmit state encoding.
package ps2_pkg;

  localparam int PS2_DATA_BITS  = 8;
  localparam int PS2_FRAME_BITS = 11;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_e;

  // A frame is good when the data bits plus the parity bit hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS-1:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchronizer for an asynchronous single-bit input, with a selectable reset level.
module sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // NOTE: sequential state uses non-blocking assignments so both flops sample the pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: samples the synchronized data line on each debounced clock strobe.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter  int TIMEOUT_CYCLES = 50000,
  localparam int CNT_W          = $clog2(TIMEOUT_CYCLES)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     bit_stb,
  input  logic                     ps2_data,
  output logic [PS2_DATA_BITS-1:0] data_out,
  output logic                     data_valid,
  output logic                     parity_err,
  output logic                     frame_err,
  output logic                     busy
);

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]       BIT_LAST = 3'(PS2_DATA_BITS - 1);

  logic                     w_bit;
  ps2_state_e               r_state;
  logic [2:0]               r_bit_cnt;
  logic [PS2_DATA_BITS-1:0] r_shift;
  logic                     r_parity;
  logic [CNT_W-1:0]         r_tmo;
  logic [PS2_DATA_BITS-1:0] r_data;
  logic                     r_valid;
  logic                     r_perr;
  logic                     r_ferr;

  // Line idles high, so the synchronizer resets to 1 to avoid a phantom start bit.
  sync2 #(.RST_VAL(1'b1)) u_sync_data (
    .clk (clk),
    .rst (rst),
    .i_d (ps2_data),
    .o_q (w_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_parity  <= 1'b0;
      r_tmo     <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_perr    <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;

      if (r_state == IDLE) begin
        r_tmo <= '0;
        if (bit_stb && !w_bit) begin
          r_state   <= DATA;
          r_bit_cnt <= '0;
        end
      end else if (bit_stb) begin
        // A strobe always wins over the timeout, even on the terminal-count cycle.
        r_tmo <= '0;
        case (r_state)
          DATA: begin
            r_shift <= {w_bit, r_shift[PS2_DATA_BITS-1:1]};
            if (r_bit_cnt == BIT_LAST) r_state <= PARITY;
            else                       r_bit_cnt <= r_bit_cnt + 3'd1;
          end
          PARITY: begin
            r_parity <= w_bit;
            r_state  <= STOP;
          end
          STOP: begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            if (!w_bit) begin
              r_ferr <= 1'b1;
            end else if (odd_parity_ok(r_shift, r_parity)) begin
              r_data  <= r_shift;
              r_valid <= 1'b1;
            end else begin
              r_perr <= 1'b1;
            end
          end
          default: r_state <= IDLE;
        endcase
      end else if (r_tmo == TMO_LAST) begin
        r_ferr    <= 1'b1;
        r_state   <= IDLE;
        r_shift   <= '0;
        r_bit_cnt <= '0;
        r_tmo     <= '0;
      end else begin
        r_tmo <= r_tmo + 1'b1;
      end
    end
  end

  assign data_out   = r_data;
  assign data_valid = r_valid;
  assign parity_err = r_perr;
  assign frame_err  = r_ferr;
  assign busy       = (r_state != IDLE);

endmodule
